mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter MAX_WAIT, default 8, idle-wait cycles before the CPU is stalled for a pending SPI access.
REQ-004 clk  in  1  single clock, cpuClock domain.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cpu_mreq_n  in  1  CPU memory request, active-low.
REQ-007 cpu_wr_n  in  1  CPU write strobe, active-low.
REQ-008 cpu_addr  in  ADDR_W  CPU address.
REQ-009 cpu_dout  in  DATA_W  CPU write data.
REQ-010 cpu_wait_n  out  1  CPU wait, active-low.
REQ-011 loading  in  1  loader mode; CPU writes blocked.
REQ-012 spi_wr  in  1  one-cycle SPI write request pulse.
REQ-013 spi_rd  in  1  one-cycle SPI read request pulse.
REQ-014 spi_addr  in  ADDR_W  SPI address, sampled with the request.
REQ-015 spi_din  in  DATA_W  SPI write data, sampled with the request.
REQ-016 spi_dout  out  DATA_W  SPI read data, registered.
REQ-017 spi_rd_valid  out  1  one-cycle pulse; spi_dout is valid.
REQ-018 spi_busy  out  1  request pending or in service.
REQ-019 spi_overflow  out  1  sticky flag; a request was dropped.
REQ-020 ram_we  out  1  RAM port A write enable.
REQ-021 ram_addr  out  ADDR_W  RAM port A address.
REQ-022 ram_din  out  DATA_W  RAM port A write data.
REQ-023 ram_dout  in  DATA_W  RAM port A read data; synchronous, 1-cycle latency.

Function
REQ-024 The block SHALL hold a one-entry request buffer: pend_valid, pend_wr, pend_addr, pend_data.
REQ-025 A spi_wr or spi_rd pulse while spi_busy=0 SHALL load the buffer on that edge.
- If spi_wr and spi_rd are asserted together, the write wins and the read is discarded without setting overflow.
REQ-026 A request arriving while spi_busy=1 SHALL be dropped, and spi_overflow SHALL set and hold until reset.
REQ-027 FSM states: IDLE, STALL, ACCESS, RDATA.
REQ-028 In IDLE and RDATA, the RAM SHALL be driven by the CPU:
- ram_addr=cpu_addr, ram_din=cpu_dout;
- ram_we = !cpu_mreq_n & !cpu_wr_n & !loading.
REQ-029 IDLE -> ACCESS when pend_valid and (loading or cpu_mreq_n=1).
REQ-030 IDLE -> STALL when pend_valid, cpu_mreq_n=0, !loading and wait_cnt=MAX_WAIT-1.
- wait_cnt increments each IDLE cycle with pend_valid, saturates, and clears on entering ACCESS.
REQ-031 STALL: cpu_wait_n=0, ram_we=0, CPU keeps the RAM; next state ACCESS.
REQ-032 ACCESS (one cycle):
- ram_addr=pend_addr, ram_din=pend_data, ram_we=pend_wr;
- cpu_wait_n=0 whenever cpu_mreq_n=0;
- pend_valid clears;
- next state RDATA if read, else IDLE.
REQ-033 RDATA: spi_dout <= ram_dout, spi_rd_valid=1 for exactly this cycle; next state IDLE.
REQ-034 Read latency SHALL be 2 cycles minimum (request edge to spi_rd_valid) when the CPU is idle or loading=1.
REQ-035 cpu_wait_n SHALL be 1 in IDLE and RDATA.
REQ-036 Outside ACCESS, ram_we SHALL never be driven by the SPI request.
REQ-037 spi_busy = pend_valid | (state != IDLE).
REQ-038 A loading transition mid-operation SHALL NOT abort an in-flight ACCESS or RDATA.

Reset
REQ-039 Reset SHALL force:
- state=IDLE, pend_valid=0, wait_cnt=0;
- spi_overflow=0, spi_dout=0, spi_rd_valid=0, cpu_wait_n=1.
REQ-040 Reset asserted during STALL, ACCESS or RDATA SHALL discard the request: no RAM write on that edge, no spi_rd_valid afterwards.
REQ-041 During reset, ram_we SHALL be 0.

Verification
REQ-042 loading=1, spi_wr addr 0x4000 data 0xA5 -> ram_we=1 with addr 0x4000, din 0xA5 exactly one cycle later; spi_busy low next cycle.
REQ-043 CPU idle, spi_rd addr 0x5800 with RAM holding 0x38 -> spi_rd_valid pulses 2 cycles later with spi_dout=0x38; cpu_wait_n stays 1.
REQ-044 cpu_mreq_n held 0, MAX_WAIT=8, spi_wr pending -> STALL entered after 8 cycles, cpu_wait_n=0 for 2 cycles, then the write occurs.
REQ-045 spi_wr, then spi_rd on the next cycle -> read dropped, spi_overflow=1 and held; the write completes normally.
REQ-046 loading=1, CPU write to 0x8000 -> ram_we stays 0; with loading=0 the same write gives ram_we=1.
REQ-047 reset asserted in ACCESS for a write -> ram_we=0 on that edge, state IDLE, spi_busy=0, spi_overflow=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared RAM port: CPU side, SPI request side and RAM port A.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  // CPU side
  logic              cpu_mreq_n;
  logic              cpu_wr_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_wait_n;
  logic              loading;
  // SPI request side
  logic              spi_wr;
  logic              spi_rd;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_din;
  logic [DATA_W-1:0] spi_dout;
  logic              spi_rd_valid;
  logic              spi_busy;
  logic              spi_overflow;
  // RAM port A
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // Arbiter side
  modport slave (
    input  cpu_mreq_n, cpu_wr_n, cpu_addr, cpu_dout, loading,
    input  spi_wr, spi_rd, spi_addr, spi_din, ram_dout,
    output cpu_wait_n, spi_dout, spi_rd_valid, spi_busy, spi_overflow,
    output ram_we, ram_addr, ram_din
  );

  // Environment side (CPU, SPI engine, RAM)
  modport master (
    output cpu_mreq_n, cpu_wr_n, cpu_addr, cpu_dout, loading,
    output spi_wr, spi_rd, spi_addr, spi_din, ram_dout,
    input  cpu_wait_n, spi_dout, spi_rd_valid, spi_busy, spi_overflow,
    input  ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares RAM port A between the CPU and a one-deep SPI request buffer. SPI accesses steal
// idle CPU cycles; after MAX_WAIT busy cycles the CPU is stalled to force the access.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StStall, StAccess, StRdata} state_e;

  state_e            state_q;
  logic              pend_valid_q;
  logic              pend_wr_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic              overflow_q;
  logic [DATA_W-1:0] spi_dout_q;
  logic              spi_req;
  logic              spi_busy;

  assign spi_req  = bus.spi_wr | bus.spi_rd;
  assign spi_busy = pend_valid_q | (state_q != StIdle);

  // Request buffer capture, overflow tracking and arbitration FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_valid_q <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      wait_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      spi_dout_q   <= '0;
    end else begin
      // spi_wr has priority; a simultaneous read is silently discarded.
      if (spi_req) begin
        if (!spi_busy) begin
          pend_valid_q <= 1'b1;
          pend_wr_q    <= bus.spi_wr;
          pend_addr_q  <= bus.spi_addr;
          pend_data_q  <= bus.spi_din;
        end else begin
          overflow_q <= 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (pend_valid_q) begin
            if (bus.loading || bus.cpu_mreq_n) begin
              state_q    <= StAccess;
              wait_cnt_q <= '0;
            end else if (wait_cnt_q == WaitLast) begin
              state_q <= StStall;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
        end
        StStall: begin
          state_q    <= StAccess;
          wait_cnt_q <= '0;
        end
        StAccess: begin
          pend_valid_q <= 1'b0;
          state_q      <= pend_wr_q ? StIdle : StRdata;
        end
        StRdata: begin
          spi_dout_q <= bus.ram_dout;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM port mux and CPU wait; the SPI request only reaches ram_we during ACCESS.
  always_comb begin
    bus.ram_addr   = bus.cpu_addr;
    bus.ram_din    = bus.cpu_dout;
    bus.ram_we     = !bus.cpu_mreq_n & !bus.cpu_wr_n & !bus.loading;
    bus.cpu_wait_n = 1'b1;
    unique case (state_q)
      StStall: begin
        bus.ram_we     = 1'b0;
        bus.cpu_wait_n = 1'b0;
      end
      StAccess: begin
        bus.ram_addr   = pend_addr_q;
        bus.ram_din    = pend_data_q;
        bus.ram_we     = pend_wr_q;
        bus.cpu_wait_n = bus.cpu_mreq_n;
      end
      default: ;
    endcase
    // An access caught by reset is abandoned before it can write.
    if (reset) begin
      bus.ram_we     = 1'b0;
      bus.cpu_wait_n = 1'b1;
    end
  end

  // Read data is forwarded straight from the RAM's output register during RDATA so it lines
  // up with spi_rd_valid, and held in spi_dout_q afterwards.
  always_comb begin
    bus.spi_rd_valid = (state_q == StRdata) & !reset;
    bus.spi_dout     = bus.spi_rd_valid ? bus.ram_dout : spi_dout_q;
    bus.spi_busy     = spi_busy;
    bus.spi_overflow = overflow_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous RAM model on port A.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mem [65536];

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .MAX_WAIT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_idle();
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_addr   = 16'h0000;
    bus.cpu_dout   = 8'h00;
  endtask

  // SPI read with an idle CPU: valid two edges after the request edge.
  task automatic spi_read(input logic [15:0] a, input logic [7:0] d);
    bus.spi_rd   = 1'b1;
    bus.spi_addr = a;
    cyc();
    bus.spi_rd = 1'b0;
    chk1("rd_idle_valid", bus.spi_rd_valid, 1'b0);
    chk1("rd_idle_busy", bus.spi_busy, 1'b1);
    cyc();
    chkv("rd_access_addr", bus.ram_addr, a);
    chk1("rd_access_we", bus.ram_we, 1'b0);
    chk1("rd_access_wait", bus.cpu_wait_n, 1'b1);
    cyc();
    chk1("rd_valid", bus.spi_rd_valid, 1'b1);
    chkv("rd_data", 16'(bus.spi_dout), 16'(d));
    chk1("rd_rdata_wait", bus.cpu_wait_n, 1'b1);
    cyc();
    chk1("rd_valid_drop", bus.spi_rd_valid, 1'b0);
    chkv("rd_data_held", 16'(bus.spi_dout), 16'(d));
    chk1("rd_done_busy", bus.spi_busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h5800] = 8'h38;
    reset        = 1'b1;
    cpu_idle();
    bus.loading  = 1'b0;
    bus.spi_wr   = 1'b0;
    bus.spi_rd   = 1'b0;
    bus.spi_addr = 16'h0000;
    bus.spi_din  = 8'h00;

    // Reset state; a CPU write during reset must not reach the RAM.
    cyc();
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_wr_n   = 1'b0;
    bus.cpu_addr   = 16'h0100;
    #1 chk1("rst_ram_we", bus.ram_we, 1'b0);
    cyc();
    chk1("rst_busy", bus.spi_busy, 1'b0);
    chk1("rst_overflow", bus.spi_overflow, 1'b0);
    chk1("rst_rd_valid", bus.spi_rd_valid, 1'b0);
    chk1("rst_wait_n", bus.cpu_wait_n, 1'b1);
    chkv("rst_spi_dout", 16'(bus.spi_dout), 16'h0000);
    cpu_idle();
    reset = 1'b0;
    cyc();

    // Loader-mode SPI write: ACCESS one edge after the request edge.
    bus.loading  = 1'b1;
    bus.spi_wr   = 1'b1;
    bus.spi_addr = 16'h4000;
    bus.spi_din  = 8'hA5;
    cyc();
    bus.spi_wr = 1'b0;
    chk1("ldw_idle_we", bus.ram_we, 1'b0);
    chk1("ldw_idle_busy", bus.spi_busy, 1'b1);
    cyc();
    chk1("ldw_we", bus.ram_we, 1'b1);
    chkv("ldw_addr", bus.ram_addr, 16'h4000);
    chkv("ldw_din", 16'(bus.ram_din), 16'h00A5);
    cyc();
    chk1("ldw_busy_low", bus.spi_busy, 1'b0);
    chk1("ldw_we_low", bus.ram_we, 1'b0);

    // Read back the loaded byte, then a preloaded byte with the CPU idle.
    spi_read(16'h4000, 8'hA5);
    bus.loading = 1'b0;
    spi_read(16'h5800, 8'h38);

    // CPU continuously busy: eight idle-wait cycles, then STALL and ACCESS.
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_addr   = 16'h1234;
    bus.spi_wr     = 1'b1;
    bus.spi_addr   = 16'h6000;
    bus.spi_din    = 8'h5A;
    cyc();
    bus.spi_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("stl_wait_idle", bus.cpu_wait_n, 1'b1);
      cyc();
    end
    chk1("stl_wait_n", bus.cpu_wait_n, 1'b0);
    chk1("stl_we", bus.ram_we, 1'b0);
    chkv("stl_addr_cpu", bus.ram_addr, 16'h1234);
    cyc();
    chk1("stl_acc_wait_n", bus.cpu_wait_n, 1'b0);
    chk1("stl_acc_we", bus.ram_we, 1'b1);
    chkv("stl_acc_addr", bus.ram_addr, 16'h6000);
    chkv("stl_acc_din", 16'(bus.ram_din), 16'h005A);
    cyc();
    chk1("stl_release", bus.cpu_wait_n, 1'b1);
    chk1("stl_busy_low", bus.spi_busy, 1'b0);
    cpu_idle();

    // Read arriving while a write is pending is dropped and flagged.
    bus.spi_wr   = 1'b1;
    bus.spi_addr = 16'h7000;
    bus.spi_din  = 8'hC3;
    cyc();
    bus.spi_wr   = 1'b0;
    bus.spi_rd   = 1'b1;
    bus.spi_addr = 16'h7001;
    chk1("ovf_before", bus.spi_overflow, 1'b0);
    cyc();
    bus.spi_rd = 1'b0;
    chk1("ovf_set", bus.spi_overflow, 1'b1);
    chk1("ovf_wr_we", bus.ram_we, 1'b1);
    chkv("ovf_wr_addr", bus.ram_addr, 16'h7000);
    chkv("ovf_wr_din", 16'(bus.ram_din), 16'h00C3);
    cyc();
    chk1("ovf_no_rd", bus.spi_rd_valid, 1'b0);
    chk1("ovf_busy_low", bus.spi_busy, 1'b0);
    repeat (3) cyc();
    chk1("ovf_held", bus.spi_overflow, 1'b1);

    // Reset during ACCESS of a write: no write, everything cleared.
    bus.spi_wr   = 1'b1;
    bus.spi_addr = 16'h7200;
    bus.spi_din  = 8'h77;
    cyc();
    bus.spi_wr = 1'b0;
    cyc();
    reset = 1'b1;
    #1 chk1("rsta_we", bus.ram_we, 1'b0);
    cyc();
    chk1("rsta_busy", bus.spi_busy, 1'b0);
    chk1("rsta_overflow", bus.spi_overflow, 1'b0);
    chkv("rsta_mem", 16'(mem[16'h7200]), 16'h0000);
    reset = 1'b0;
    cyc();

    // Reset during RDATA: no read-valid pulse.
    bus.spi_rd   = 1'b1;
    bus.spi_addr = 16'h5800;
    cyc();
    bus.spi_rd = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    #1 chk1("rstr_valid", bus.spi_rd_valid, 1'b0);
    cyc();
    reset = 1'b0;
    chk1("rstr_valid_after", bus.spi_rd_valid, 1'b0);
    cyc();
    chk1("rstr_valid_later", bus.spi_rd_valid, 1'b0);
    chk1("rstr_busy", bus.spi_busy, 1'b0);

    // Simultaneous write and read: write wins, no overflow.
    bus.spi_wr   = 1'b1;
    bus.spi_rd   = 1'b1;
    bus.spi_addr = 16'h7100;
    bus.spi_din  = 8'h11;
    cyc();
    bus.spi_wr = 1'b0;
    bus.spi_rd = 1'b0;
    chk1("both_ovf", bus.spi_overflow, 1'b0);
    cyc();
    chk1("both_we", bus.ram_we, 1'b1);
    chkv("both_din", 16'(bus.ram_din), 16'h0011);
    cyc();
    chk1("both_no_rd", bus.spi_rd_valid, 1'b0);
    chk1("both_ovf_after", bus.spi_overflow, 1'b0);

    // CPU writes are blocked in loader mode.
    bus.loading    = 1'b1;
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_wr_n   = 1'b0;
    bus.cpu_addr   = 16'h8000;
    bus.cpu_dout   = 8'h99;
    #1 chk1("cpuw_loading_we", bus.ram_we, 1'b0);
    bus.loading = 1'b0;
    #1 chk1("cpuw_we", bus.ram_we, 1'b1);
    chkv("cpuw_addr", bus.ram_addr, 16'h8000);
    chkv("cpuw_din", 16'(bus.ram_din), 16'h0099);

    // Loader mode with CPU requesting: ACCESS immediately, CPU waits only then.
    cyc();
    bus.loading  = 1'b1;
    bus.spi_wr   = 1'b1;
    bus.spi_addr = 16'h8100;
    bus.spi_din  = 8'h42;
    cyc();
    bus.spi_wr = 1'b0;
    chk1("ldc_idle_wait", bus.cpu_wait_n, 1'b1);
    chk1("ldc_idle_we", bus.ram_we, 1'b0);
    cyc();
    chk1("ldc_acc_we", bus.ram_we, 1'b1);
    chkv("ldc_acc_addr", bus.ram_addr, 16'h8100);
    chk1("ldc_acc_wait", bus.cpu_wait_n, 1'b0);
    cyc();
    chk1("ldc_done_wait", bus.cpu_wait_n, 1'b1);
    chk1("ldc_done_busy", bus.spi_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
